// File: rtl/id_ex_stage.sv
// ----------------------------------------------------------------------------
// id_ex_stage
//   Decode / operand-fetch stage and ID/EX pipeline register of the 16-bit
//   pipelined CPU. Holds the general register file, selects register or
//   zero-extended immediate operands, forwards results still in flight from
//   EX, MEM and WB, and raises a load-use stall.
//
// Ports
//   clock, reset         rising-edge clock, asynchronous active-high reset
//   id_ir                instruction currently in ID
//   flush                taken branch: squash id_ir into a bubble
//   ex_alu_o             ALU result of the instruction in EX (forward source)
//   mem_ir, mem_result   instruction in MEM and its result (forward source)
//   wb_ir, wb_data       instruction in WB and its write-back value
//   ex_ir                registered instruction handed to EX
//   reg_A, reg_B         registered ALU operands
//   smdr                 registered store data
//   stall                combinational load-use stall (0 while flush=1)
// ----------------------------------------------------------------------------
module id_ex_stage #(
    parameter int unsigned DW     = 16,
    parameter int unsigned NREG   = 8,
    parameter logic [15:0] NOP_IR = 16'h0000
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [15:0]   id_ir,
    input  logic          flush,
    input  logic [DW-1:0] ex_alu_o,
    input  logic [15:0]   mem_ir,
    input  logic [DW-1:0] mem_result,
    input  logic [15:0]   wb_ir,
    input  logic [DW-1:0] wb_data,
    output logic [15:0]   ex_ir,
    output logic [DW-1:0] reg_A,
    output logic [DW-1:0] reg_B,
    output logic [DW-1:0] smdr,
    output logic          stall
);

    // Opcode encodings (ISA table)
    localparam logic [4:0] OP_NOP   = 5'b00000;
    localparam logic [4:0] OP_LOAD  = 5'b00010;
    localparam logic [4:0] OP_STORE = 5'b00011;
    localparam logic [4:0] OP_SHL   = 5'b00100;
    localparam logic [4:0] OP_CAL   = 5'b00101;
    localparam logic [4:0] OP_SHR   = 5'b00110;
    localparam logic [4:0] OP_CAR   = 5'b00111;
    localparam logic [4:0] OP_ADD   = 5'b01000;
    localparam logic [4:0] OP_ADDI  = 5'b01001;
    localparam logic [4:0] OP_SUB   = 5'b01010;
    localparam logic [4:0] OP_SUBI  = 5'b01011;
    localparam logic [4:0] OP_CMP   = 5'b01100;
    localparam logic [4:0] OP_AND   = 5'b01101;
    localparam logic [4:0] OP_OR    = 5'b01110;
    localparam logic [4:0] OP_XOR   = 5'b01111;
    localparam logic [4:0] OP_MOVI  = 5'b10000;
    localparam logic [4:0] OP_ADDC  = 5'b10001;
    localparam logic [4:0] OP_SUBC  = 5'b10010;
    localparam logic [4:0] OP_JZ    = 5'b11010;
    localparam logic [4:0] OP_JNZ   = 5'b11011;
    localparam logic [4:0] OP_JS    = 5'b11100;
    localparam logic [4:0] OP_JNS   = 5'b11101;
    localparam logic [4:0] OP_JC    = 5'b11110;
    localparam logic [4:0] OP_JNC   = 5'b11111;

    function automatic logic is_writer(input logic [4:0] op);
        return op inside {OP_LOAD, OP_ADD, OP_ADDI, OP_MOVI, OP_ADDC, OP_SUB, OP_SUBI,
                          OP_SUBC, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR, OP_CAL, OP_CAR};
    endfunction

    logic [DW-1:0] gr_q [NREG];
    logic [DW-1:0] gr_d [NREG];
    logic [DW-1:0] gr_rd [NREG];
    logic [15:0]   ex_ir_q, ex_ir_d;
    logic [DW-1:0] reg_a_q, reg_a_d, reg_b_q, reg_b_d, smdr_q, smdr_d;

    logic [4:0]    id_op, ex_op;
    logic [2:0]    id_r1, id_r2, id_r3, ex_dst, mem_dst, wb_dst;
    logic [DW-1:0] imm8, imm4;
    logic          ex_fwd, mem_wr, wb_wr;
    logic [DW-1:0] a_sel, b_sel, s_sel;
    logic          rd_r1, rd_r2, rd_r3;

    // Only opcode and destination of the downstream instructions matter here
    logic unused_ir_bits;
    assign unused_ir_bits = ^{mem_ir[7:0], wb_ir[7:0], ex_ir_q[7:0]};

    assign id_op   = id_ir[15:11];
    assign id_r1   = id_ir[10:8];
    assign id_r2   = id_ir[6:4];
    assign id_r3   = id_ir[2:0];
    assign imm8    = {{(DW-8){1'b0}}, id_ir[7:0]};
    assign imm4    = {{(DW-4){1'b0}}, id_ir[3:0]};
    assign ex_op   = ex_ir_q[15:11];
    assign ex_dst  = ex_ir_q[10:8];
    assign mem_dst = mem_ir[10:8];
    assign wb_dst  = wb_ir[10:8];

    // A LOAD in EX has no data yet; that case is handled by the stall instead
    assign ex_fwd = is_writer(ex_op) && (ex_op != OP_LOAD);
    assign mem_wr = is_writer(mem_ir[15:11]);
    assign wb_wr  = is_writer(wb_ir[15:11]);

    // Forwarded view of every register; later assignments win (EX > MEM > WB > file)
    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            gr_rd[i] = gr_q[i];
            if (wb_wr  && wb_dst  == 3'(i)) gr_rd[i] = wb_data;
            if (mem_wr && mem_dst == 3'(i)) gr_rd[i] = mem_result;
            if (ex_fwd && ex_dst  == 3'(i)) gr_rd[i] = ex_alu_o;
        end
    end

    always_comb begin
        a_sel = '0;
        b_sel = '0;
        s_sel = '0;
        rd_r1 = 1'b0;
        rd_r2 = 1'b0;
        rd_r3 = 1'b0;
        case (id_op)
            OP_ADD, OP_ADDC, OP_SUB, OP_SUBC, OP_CMP, OP_AND, OP_OR, OP_XOR: begin
                a_sel = gr_rd[id_r2];
                b_sel = gr_rd[id_r3];
                rd_r2 = 1'b1;
                rd_r3 = 1'b1;
            end
            OP_ADDI, OP_SUBI: begin
                a_sel = gr_rd[id_r1];
                b_sel = imm8;
                rd_r1 = 1'b1;
            end
            OP_MOVI: b_sel = imm8;
            OP_LOAD: begin
                a_sel = gr_rd[id_r2];
                b_sel = imm4;
                rd_r2 = 1'b1;
            end
            OP_STORE: begin
                a_sel = gr_rd[id_r2];
                b_sel = imm4;
                s_sel = gr_rd[id_r1];
                rd_r1 = 1'b1;
                rd_r2 = 1'b1;
            end
            OP_SHL, OP_SHR, OP_CAL, OP_CAR: begin
                a_sel = gr_rd[id_r1];
                b_sel = imm4;
                rd_r1 = 1'b1;
            end
            OP_JZ, OP_JNZ, OP_JS, OP_JNS, OP_JC, OP_JNC: begin
                a_sel = gr_rd[id_r1];
                b_sel = imm8;
                rd_r1 = 1'b1;
            end
            default: ;
        endcase
    end

    assign stall = !flush && (ex_op == OP_LOAD) &&
                   ((rd_r1 && id_r1 == ex_dst) || (rd_r2 && id_r2 == ex_dst) ||
                    (rd_r3 && id_r3 == ex_dst));

    always_comb begin
        if (flush || stall) begin
            ex_ir_d = NOP_IR;
            reg_a_d = '0;
            reg_b_d = '0;
            smdr_d  = '0;
        end else begin
            ex_ir_d = id_ir;
            reg_a_d = a_sel;
            reg_b_d = b_sel;
            smdr_d  = s_sel;
        end
    end

    always_comb begin
        for (int i = 0; i < NREG; i++) gr_d[i] = gr_q[i];
        if (wb_wr) gr_d[wb_dst] = wb_data;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) gr_q[i] <= '0;
            ex_ir_q <= NOP_IR;
            reg_a_q <= '0;
            reg_b_q <= '0;
            smdr_q  <= '0;
        end else begin
            for (int i = 0; i < NREG; i++) gr_q[i] <= gr_d[i];
            ex_ir_q <= ex_ir_d;
            reg_a_q <= reg_a_d;
            reg_b_q <= reg_b_d;
            smdr_q  <= smdr_d;
        end
    end

    assign ex_ir = ex_ir_q;
    assign reg_A = reg_a_q;
    assign reg_B = reg_b_q;
    assign smdr  = smdr_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// ----------------------------------------------------------------------------
// tb_id_ex_stage
//   Directed scenarios plus random traffic against a behavioural model of the
//   ID stage (register array, priority read rule, operand table).
// ----------------------------------------------------------------------------
module tb_id_ex_stage;

    localparam logic [4:0] OP_NOP   = 5'b00000;
    localparam logic [4:0] OP_LOAD  = 5'b00010;
    localparam logic [4:0] OP_STORE = 5'b00011;
    localparam logic [4:0] OP_SHL   = 5'b00100;
    localparam logic [4:0] OP_CAL   = 5'b00101;
    localparam logic [4:0] OP_SHR   = 5'b00110;
    localparam logic [4:0] OP_CAR   = 5'b00111;
    localparam logic [4:0] OP_ADD   = 5'b01000;
    localparam logic [4:0] OP_ADDI  = 5'b01001;
    localparam logic [4:0] OP_SUB   = 5'b01010;
    localparam logic [4:0] OP_SUBI  = 5'b01011;
    localparam logic [4:0] OP_CMP   = 5'b01100;
    localparam logic [4:0] OP_AND   = 5'b01101;
    localparam logic [4:0] OP_OR    = 5'b01110;
    localparam logic [4:0] OP_XOR   = 5'b01111;
    localparam logic [4:0] OP_MOVI  = 5'b10000;
    localparam logic [4:0] OP_ADDC  = 5'b10001;
    localparam logic [4:0] OP_SUBC  = 5'b10010;
    localparam logic [4:0] OP_JZ    = 5'b11010;
    localparam logic [4:0] OP_JNZ   = 5'b11011;
    localparam logic [4:0] OP_JS    = 5'b11100;
    localparam logic [4:0] OP_JNS   = 5'b11101;
    localparam logic [4:0] OP_JC    = 5'b11110;
    localparam logic [4:0] OP_JNC   = 5'b11111;

    localparam logic [15:0] NOPW = 16'h0000;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] id_ir = '0;
    logic        flush = 1'b0;
    logic [15:0] ex_alu_o = '0;
    logic [15:0] mem_ir = '0;
    logic [15:0] mem_result = '0;
    logic [15:0] wb_ir = '0;
    logic [15:0] wb_data = '0;
    logic [15:0] ex_ir, reg_A, reg_B, smdr;
    logic        stall;

    always #5 clock = ~clock;

    id_ex_stage dut (
        .clock      (clock),
        .reset      (reset),
        .id_ir      (id_ir),
        .flush      (flush),
        .ex_alu_o   (ex_alu_o),
        .mem_ir     (mem_ir),
        .mem_result (mem_result),
        .wb_ir      (wb_ir),
        .wb_data    (wb_data),
        .ex_ir      (ex_ir),
        .reg_A      (reg_A),
        .reg_B      (reg_B),
        .smdr       (smdr),
        .stall      (stall)
    );

    int total = 0;
    int bad = 0;

    // Reference state
    logic [15:0] gr_m [8];
    logic [15:0] m_ex_ir, m_a, m_b, m_s;
    logic        obs_stall;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        total++;
        assert (obs === expv)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic logic m_writes(input logic [15:0] ir);
        return ir[15:11] inside {OP_LOAD, OP_ADD, OP_ADDI, OP_MOVI, OP_ADDC, OP_SUB, OP_SUBI,
                                 OP_SUBC, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR, OP_CAL,
                                 OP_CAR};
    endfunction

    // Value an ID read of register x should see
    function automatic logic [15:0] m_rd(input int x);
        if (m_writes(m_ex_ir) && m_ex_ir[15:11] != OP_LOAD && int'(m_ex_ir[10:8]) == x)
            return ex_alu_o;
        if (m_writes(mem_ir) && int'(mem_ir[10:8]) == x) return mem_result;
        if (m_writes(wb_ir) && int'(wb_ir[10:8]) == x) return wb_data;
        return gr_m[x];
    endfunction

    // Operand table; 'used' marks every register the opcode reads
    task automatic m_ops(input logic [15:0] ir, output logic [15:0] a, output logic [15:0] b,
                         output logic [15:0] s, output logic [7:0] used);
        int r1 = int'(ir[10:8]);
        int r2 = int'(ir[6:4]);
        int r3 = int'(ir[2:0]);
        logic [15:0] i8 = {8'h00, ir[7:0]};
        logic [15:0] i4 = {12'h000, ir[3:0]};
        a = 0; b = 0; s = 0; used = 0;
        case (ir[15:11])
            OP_ADD, OP_ADDC, OP_SUB, OP_SUBC, OP_CMP, OP_AND, OP_OR, OP_XOR: begin
                a = m_rd(r2); b = m_rd(r3); used[r2] = 1; used[r3] = 1;
            end
            OP_ADDI, OP_SUBI: begin a = m_rd(r1); b = i8; used[r1] = 1; end
            OP_MOVI: b = i8;
            OP_LOAD: begin a = m_rd(r2); b = i4; used[r2] = 1; end
            OP_STORE: begin
                a = m_rd(r2); b = i4; s = m_rd(r1); used[r1] = 1; used[r2] = 1;
            end
            OP_SHL, OP_SHR, OP_CAL, OP_CAR: begin a = m_rd(r1); b = i4; used[r1] = 1; end
            OP_JZ, OP_JNZ, OP_JS, OP_JNS, OP_JC, OP_JNC: begin
                a = m_rd(r1); b = i8; used[r1] = 1;
            end
            default: ;
        endcase
    endtask

    // One pipeline cycle: drive at negedge, check stall before the edge, outputs after
    task automatic step(input logic [15:0] ir, input logic fl, input logic [15:0] alu,
                        input logic [15:0] mir, input logic [15:0] mres,
                        input logic [15:0] wir, input logic [15:0] wdat);
        logic [15:0] na, nb, ns;
        logic [7:0]  used;
        logic        exp_st;
        @(negedge clock);
        id_ir = ir; flush = fl; ex_alu_o = alu;
        mem_ir = mir; mem_result = mres; wb_ir = wir; wb_data = wdat;
        #1;
        m_ops(id_ir, na, nb, ns, used);
        exp_st = !flush && m_ex_ir[15:11] == OP_LOAD && used[m_ex_ir[10:8]];
        obs_stall = stall;
        chk("stall", {15'b0, stall}, {15'b0, exp_st});
        @(posedge clock);
        if (flush || exp_st) begin
            m_ex_ir = NOPW; m_a = 0; m_b = 0; m_s = 0;
        end else begin
            m_ex_ir = id_ir; m_a = na; m_b = nb; m_s = ns;
        end
        if (m_writes(wb_ir)) gr_m[wb_ir[10:8]] = wb_data;
        #1;
        chk("ex_ir", ex_ir, m_ex_ir);
        chk("reg_A", reg_A, m_a);
        chk("reg_B", reg_B, m_b);
        chk("smdr", smdr, m_s);
    endtask

    task automatic nop_step(input logic [15:0] ir);
        step(ir, 1'b0, 16'h0, NOPW, 16'h0, NOPW, 16'h0);
    endtask

    task automatic do_reset();
        @(negedge clock);
        id_ir = NOPW; flush = 0; mem_ir = NOPW; wb_ir = NOPW;
        reset = 1'b1;
        #1;
        for (int i = 0; i < 8; i++) gr_m[i] = 0;
        m_ex_ir = NOPW; m_a = 0; m_b = 0; m_s = 0;
        // Asynchronous: outputs clear before any clock edge
        chk("rst_ex_ir", ex_ir, NOPW);
        chk("rst_reg_A", reg_A, 16'h0);
        chk("rst_reg_B", reg_B, 16'h0);
        chk("rst_smdr", smdr, 16'h0);
        chk("rst_stall", {15'b0, stall}, 16'h0);
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic random_run(input int n);
        logic [31:0] r;
        logic [15:0] ir, mir, wir;
        logic        hold = 0;
        ir = NOPW;
        for (int k = 0; k < n; k++) begin
            if (!hold) begin
                r = $urandom;
                ir = r[15:0];
                if ($urandom_range(0, 3) == 0) ir[15:11] = OP_LOAD;
            end
            r = $urandom;
            mir = r[15:0];
            wir = r[31:16];
            step(ir, $urandom_range(0, 7) == 0, 16'($urandom), mir, 16'($urandom), wir,
                 16'($urandom));
            hold = obs_stall;
        end
    endtask

    initial begin
        do_reset();
        random_run(100);

        // Mid-run reset, then MOVI r1,0x12
        do_reset();
        nop_step({OP_MOVI, 3'd1, 8'h12});
        chk("movi_ir", ex_ir, {OP_MOVI, 3'd1, 8'h12});
        chk("movi_A", reg_A, 16'h0000);
        chk("movi_B", reg_B, 16'h0012);
        chk("movi_stall", {15'b0, obs_stall}, 16'h0);

        // EX forward beats MEM forward
        nop_step({OP_ADD, 3'd1, 1'b0, 3'd2, 1'b0, 3'd3});
        step({OP_ADD, 3'd3, 1'b0, 3'd1, 1'b0, 3'd2}, 1'b0, 16'h00F0,
             {OP_ADD, 3'd1, 8'h00}, 16'h1111, NOPW, 16'h0);
        chk("ex_over_mem", reg_A, 16'h00F0);

        // Load-use: bubble, then issue with MEM forward of the load data
        nop_step({OP_LOAD, 3'd2, 1'b0, 3'd0, 4'h1});
        nop_step({OP_ADD, 3'd4, 1'b0, 3'd2, 1'b0, 3'd5});
        chk("lu_stall", {15'b0, obs_stall}, 16'h1);
        chk("lu_bubble_ir", ex_ir, 16'h0000);
        chk("lu_bubble_A", reg_A, 16'h0000);
        chk("lu_bubble_B", reg_B, 16'h0000);
        step({OP_ADD, 3'd4, 1'b0, 3'd2, 1'b0, 3'd5}, 1'b0, 16'h0,
             {OP_LOAD, 3'd2, 1'b0, 3'd0, 4'h1}, 16'hABCD, NOPW, 16'h0);
        chk("lu_issue_stall", {15'b0, obs_stall}, 16'h0);
        chk("lu_issue_ir", ex_ir, {OP_ADD, 3'd4, 1'b0, 3'd2, 1'b0, 3'd5});
        chk("lu_issue_A", reg_A, 16'hABCD);

        // WB write-through into a STORE, then the file holds the value
        step({OP_STORE, 3'd6, 1'b0, 3'd2, 4'd3}, 1'b0, 16'h0, NOPW, 16'h0,
             {OP_MOVI, 3'd6, 8'h00}, 16'hBEEF);
        chk("wt_smdr", smdr, 16'hBEEF);
        chk("wt_B", reg_B, 16'h0003);
        nop_step(NOPW);
        nop_step({OP_ADD, 3'd0, 1'b0, 3'd6, 1'b0, 3'd6});
        chk("file_A", reg_A, 16'hBEEF);
        chk("file_B", reg_B, 16'hBEEF);

        // Flush overrides a load-use condition
        nop_step({OP_LOAD, 3'd2, 1'b0, 3'd0, 4'h1});
        step({OP_ADD, 3'd4, 1'b0, 3'd2, 1'b0, 3'd5}, 1'b1, 16'h0, NOPW, 16'h0, NOPW, 16'h0);
        chk("fl_stall", {15'b0, obs_stall}, 16'h0);
        chk("fl_ir", ex_ir, 16'h0000);

        // SHL with register from file, then CMP is not a writer
        step(NOPW, 1'b0, 16'h0, NOPW, 16'h0, {OP_MOVI, 3'd7, 8'h01}, 16'h0001);
        nop_step(NOPW);
        nop_step({OP_SHL, 3'd7, 1'b0, 3'd0, 4'd4});
        chk("shl_A", reg_A, 16'h0001);
        chk("shl_B", reg_B, 16'h0004);
        nop_step({OP_CMP, 3'd0, 1'b0, 3'd2, 1'b0, 3'd3});
        chk("cmp_ir", ex_ir, {OP_CMP, 3'd0, 1'b0, 3'd2, 1'b0, 3'd3});
        step({OP_ADD, 3'd1, 1'b0, 3'd0, 1'b0, 3'd0}, 1'b0, 16'hDEAD,
             {OP_CMP, 3'd0, 1'b0, 3'd2, 1'b0, 3'd3}, 16'hDEAD,
             {OP_CMP, 3'd0, 1'b0, 3'd2, 1'b0, 3'd3}, 16'hDEAD);
        chk("cmp_nofwd_A", reg_A, 16'h0000);
        nop_step(NOPW);
        nop_step({OP_ADD, 3'd1, 1'b0, 3'd0, 1'b0, 3'd0});
        chk("cmp_nowrite_A", reg_A, 16'h0000);

        random_run(400);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
